// File: rtl/pipe_reg_chain.sv
// Elastic register chain: DEPTH valid/data stages with bubble collapse,
// global stall, synchronous flush and an occupancy count.
module pipe_reg_chain #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        DEPTH      = 3,
  parameter logic [DATA_W-1:0]  PRESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LAST  = DEPTH - 1;

  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  adv;
  logic [CNT_W-1:0]  cnt_q;
  logic              run;
  logic              in_xfer;
  logic              out_xfer;

  // A stage may advance if any stage at or downstream of it is empty, or the sink drains.
  for (genvar k = 0; k < DEPTH; k++) begin : g_adv
    assign adv[k] = out_ready | ~(&v_q[LAST:k]);
  end

  assign run       = en & ~flush;
  assign in_ready  = run & adv[0];
  assign out_valid = run & v_q[LAST];
  assign out_data  = d_q[LAST];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Stage data/valid registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < int'(DEPTH); k++) d_q[k] <= PRESET_VAL;
      v_q <= '0;
    end else if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) d_q[k] <= PRESET_VAL;
      v_q <= '0;
    end else if (en) begin
      if (adv[0]) begin
        d_q[0] <= in_data;
        v_q[0] <= in_xfer;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (adv[k]) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end
  end

  // Occupancy tracks accepted minus delivered items.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end
  end

  assign count = cnt_q;
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain at DEPTH=3, DATA_W=8, PRESET_VAL=0xA5.
module tb_pipe_reg_chain;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 3;
  localparam logic [7:0]  PRESET = 8'hA5;

  logic              clk = 1'b0;
  logic              arst;
  logic              en;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [1:0]        count;
  logic              full;
  logic              empty;

  int checks   = 0;
  int failures = 0;

  pipe_reg_chain #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PRESET_VAL(PRESET)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    arst = 1'b1; en = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_odata", 32'(out_data), 32'(PRESET));
    #20;
    arst = 1'b0;
    #1;
    chk("rst_iready", 32'(in_ready), 1);
    tick();

    // Streaming: three items, first out_valid after DEPTH edges
    drive(1'b1, 8'h11, 1'b1);
    chk("s_iready", 32'(in_ready), 1);
    tick();
    drive(1'b1, 8'h22, 1'b1);
    chk("s_cnt1", 32'(count), 1);
    chk("s_ov1", 32'(out_valid), 0);
    tick();
    drive(1'b1, 8'h33, 1'b1);
    chk("s_ov2", 32'(out_valid), 0);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("s_ov3", 32'(out_valid), 1);
    chk("s_od3", 32'(out_data), 32'h11);
    chk("s_cnt3", 32'(count), 3);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("s_ov4", 32'(out_valid), 1);
    chk("s_od4", 32'(out_data), 32'h22);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("s_ov5", 32'(out_valid), 1);
    chk("s_od5", 32'(out_data), 32'h33);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("s_ov6", 32'(out_valid), 0);
    chk("s_empty6", 32'(empty), 1);

    // Backpressure: fill, 4th blocked, then simultaneous in/out while full
    drive(1'b1, 8'h11, 1'b0); tick();
    drive(1'b1, 8'h22, 1'b0); tick();
    drive(1'b1, 8'h33, 1'b0);
    chk("bp_iready2", 32'(in_ready), 1);
    tick();
    drive(1'b1, 8'h44, 1'b0);
    chk("bp_iready_full", 32'(in_ready), 0);
    chk("bp_full", 32'(full), 1);
    chk("bp_cnt", 32'(count), 3);
    chk("bp_od", 32'(out_data), 32'h11);
    tick();
    drive(1'b1, 8'h44, 1'b0);
    chk("bp_hold_cnt", 32'(count), 3);
    chk("bp_hold_od", 32'(out_data), 32'h11);
    drive(1'b1, 8'h44, 1'b1);
    chk("bp_iready_pass", 32'(in_ready), 1);
    chk("bp_ov_pass", 32'(out_valid), 1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("bp_cnt_pass", 32'(count), 3);
    chk("bp_od_22", 32'(out_data), 32'h22);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("bp_od_33", 32'(out_data), 32'h33);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("bp_od_44", 32'(out_data), 32'h44);
    chk("bp_cnt1", 32'(count), 1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("bp_empty", 32'(empty), 1);

    // Bubble collapse: items in stages 0 and 2, sink stalled
    drive(1'b1, 8'h5A, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    drive(1'b1, 8'h6B, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("bub_iready", 32'(in_ready), 1);
    chk("bub_cnt", 32'(count), 2);
    chk("bub_od", 32'(out_data), 32'h5A);
    tick();
    drive(1'b1, 8'h7C, 1'b0);
    chk("bub_cnt_after", 32'(count), 2);
    chk("bub_iready_after", 32'(in_ready), 1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("bub_full", 32'(full), 1);
    chk("bub_od_a", 32'(out_data), 32'h5A);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("bub_od_b", 32'(out_data), 32'h6B);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("bub_od_c", 32'(out_data), 32'h7C);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("bub_empty", 32'(empty), 1);

    // Global stall with two items, one already at the output stage
    drive(1'b1, 8'h71, 1'b0); tick();
    drive(1'b1, 8'h72, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      en = 1'b0;
      drive(1'b1, 8'h99, 1'b1);
      chk("stall_ov", 32'(out_valid), 0);
      chk("stall_ir", 32'(in_ready), 0);
      tick();
    end
    chk("stall_cnt", 32'(count), 2);
    en = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    chk("stall_od_a", 32'(out_data), 32'h71);
    chk("stall_ov_a", 32'(out_valid), 1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("stall_od_b", 32'(out_data), 32'h72);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("stall_empty", 32'(empty), 1);

    // Flush while full with a valid input
    drive(1'b1, 8'h81, 1'b0); tick();
    drive(1'b1, 8'h82, 1'b0); tick();
    drive(1'b1, 8'h83, 1'b0); tick();
    flush = 1'b1;
    drive(1'b1, 8'h84, 1'b1);
    chk("fl_full", 32'(full), 1);
    chk("fl_ov", 32'(out_valid), 0);
    chk("fl_ir", 32'(in_ready), 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("fl_cnt", 32'(count), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_od", 32'(out_data), 32'(PRESET));
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("fl_dropped", 32'(count), 0);

    // Asynchronous reset between edges with two items in flight
    drive(1'b1, 8'h91, 1'b0); tick();
    drive(1'b1, 8'h92, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    chk("ar_cnt_pre", 32'(count), 2);
    chk("ar_od_pre", 32'(out_data), 32'h91);
    arst = 1'b1;
    #1;
    chk("ar_cnt", 32'(count), 0);
    chk("ar_empty", 32'(empty), 1);
    chk("ar_od", 32'(out_data), 32'(PRESET));
    chk("ar_ov", 32'(out_valid), 0);
    #1;
    arst = 1'b0;
    tick();
    drive(1'b1, 8'hE1, 1'b1);
    chk("ar_ir_after", 32'(in_ready), 1);
    tick(); drive(1'b0, 8'h00, 1'b1);
    tick(); drive(1'b0, 8'h00, 1'b1);
    tick(); drive(1'b0, 8'h00, 1'b1);
    chk("ar_ov_new", 32'(out_valid), 1);
    chk("ar_od_new", 32'(out_data), 32'hE1);
    chk("ar_cnt_new", 32'(count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter: DATA_W, default 32, data width in bits (>=1).
REQ-002 Parameter: DEPTH, default 3, number of register stages (>=1).
REQ-003 Parameter: PRESET_VAL, default 0, data value held by every stage after reset or flush.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: arst  input  1  reset, asynchronous, active-high.
REQ-006 Port: en  input  1  global enable; 0 = full stall.
REQ-007 Port: flush  input  1  synchronous clear of all stages.
REQ-008 Port: in_valid  input  1  upstream data valid.
REQ-009 Port: in_data  input  DATA_W  upstream data.
REQ-010 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-011 Port: out_valid  output  1  out_data valid this cycle.
REQ-012 Port: out_data  output  DATA_W  data of last stage (stage DEPTH-1).
REQ-013 Port: out_ready  input  1  downstream accepts out_data.
REQ-014 Port: count  output  $clog2(DEPTH+1)  number of valid stages.
REQ-015 Port: full / empty  output  1 each  count==DEPTH / count==0.

Function
REQ-016 Each stage k (0 = input side, DEPTH-1 = output side) SHALL hold a data register d[k] and a valid bit v[k].
REQ-017 Advance condition: adv[DEPTH-1] = ~v[DEPTH-1] | out_ready; adv[k] = ~v[k] | adv[k+1] for k<DEPTH-1 (bubble collapse).
REQ-018 in_ready SHALL equal en & ~flush & adv[0]; in_ready is combinationally dependent on out_ready.
REQ-019 out_valid SHALL equal en & ~flush & v[DEPTH-1]; out_data SHALL equal d[DEPTH-1] at all times.
REQ-020 Input transfer occurs when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-021 When en=1, flush=0 and adv[k]=1: d[k] <= d[k-1], v[k] <= v[k-1]; for stage 0: d[0] <= in_data, v[0] <= in_valid & in_ready.
REQ-022 Stages with adv[k]=0 SHALL hold d[k] and v[k]; invalid stages not loading hold their data unchanged.
REQ-023 en=0 and flush=0: all d, v, count held; no transfers regardless of in_valid/out_ready.
REQ-024 flush=1 (any en): next edge all v <= 0, all d <= PRESET_VAL, count <= 0; input on that cycle is dropped, no output transfer.
REQ-025 Latency: empty chain, continuous out_ready=1: item accepted at edge t appears with out_valid=1 in the cycle after edge t+DEPTH-1 (DEPTH edges to reach the output register).
REQ-026 Throughput: one item per cycle when en=1 and out_ready=1 continuously, including when full.
REQ-027 Full with out_ready=1: simultaneous input and output transfer SHALL occur; count unchanged.
REQ-028 count SHALL update as count + in_xfer - out_xfer, saturating impossible by construction; never exceeds DEPTH.
REQ-029 Order SHALL be preserved; no item duplicated or lost except by flush or reset.
REQ-030 DEPTH=1: single stage, same rules; in_ready = en & ~flush & (~v[0] | out_ready).

Reset
REQ-031 arst=1 SHALL immediately (no clock) force all v=0, all d=PRESET_VAL, count=0, out_valid=0, full=0, empty=1.
REQ-032 arst deassertion SHALL be observed at the next clk edge; in_ready SHALL be 1 in the first cycle after deassertion if en=1, flush=0.
REQ-033 arst asserted mid-transfer SHALL discard all in-flight items; no output transfer reported.

Verification
REQ-034 DEPTH=3, DATA_W=8: push 0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 on three consecutive cycles, first out_valid 3 edges after first accept.
REQ-035 out_ready=0, push 4 items -> 3 accepted, count=3, full=1, in_ready=0 on 4th; raise out_ready -> 4th accepted same cycle as 0x11 leaves, count stays 3.
REQ-036 Items in stages 0 and 2 only (bubble in stage 1), out_ready=0 -> stage 0 item advances to stage 1, in_ready=1, count unchanged.
REQ-037 Chain holding 2 items, en=0 for 5 cycles with in_valid=1, out_ready=1 -> no transfers, count=2, out_valid=0; en=1 -> resumes in order.
REQ-038 Chain full, flush=1 with in_valid=1 -> next cycle count=0, empty=1, out_data=PRESET_VAL, input dropped.
REQ-039 arst pulsed between clock edges while count=2 -> outputs reset immediately, out_data=PRESET_VAL, empty=1 before next edge.
